// File: rtl/queue_mp.sv
// Multi-port circular FIFO: up to NIN enqueues and NOUT dequeues per cycle, registered ready/valid flags.
// Optional high-water-mark output enabled by defining QUEUE_MP_HWM_EN.
module queue_mp #(
    parameter type ET        = logic [31:0],
    parameter int  SIZE      = 4,
    parameter int  NIN       = 2,
    parameter int  NOUT      = 2,
    parameter int  AF_MARGIN = 1,
    localparam int PTRW      = $clog2(SIZE),
    localparam int CNTW      = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    output logic [CNTW-1:0] count,
    output logic            almost_full,
    input  logic [NIN-1:0]  in_val,
    output logic [NIN-1:0]  in_rdy,
    input  ET               in [NIN],
    output logic [NOUT-1:0] out_val,
    input  logic [NOUT-1:0] out_rdy,
    output ET               out [NOUT]
`ifdef QUEUE_MP_HWM_EN
    ,
    output logic [CNTW-1:0] hwm
`endif
);

    logic [PTRW-1:0] wptr, rptr;
    ET               mem [SIZE];
    int              npush, npop, ncnt;

    // Both operands are already below SIZE, so one conditional subtract normalises the sum.
    function automatic logic [PTRW-1:0] wrap(input int a);
        return PTRW'((a >= SIZE) ? a - SIZE : a);
    endfunction

    // Accepted lanes form a leading run; the first lane that does not handshake ends it.
    always_comb begin
        logic stop_in, stop_out;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        npush    = 0;
        npop     = 0;
        stop_in  = 1'b0;
        stop_out = 1'b0;
        for (int i = 0; i < NIN; i++) begin
            if (!stop_in && in_val[i] && in_rdy[i]) npush = i + 1;
            else                                     stop_in = 1'b1;
        end
        for (int j = 0; j < NOUT; j++) begin
            if (!stop_out && out_val[j] && out_rdy[j]) npop = j + 1;
            else                                        stop_out = 1'b1;
        end
        ncnt = init ? 0 : int'(count) + npush - npop;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            in_rdy  <= '1;
            out_val <= '0;
        end else begin
            if (init) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                wptr <= wrap(int'(wptr) + npush);
                rptr <= wrap(int'(rptr) + npop);
            end
            count <= CNTW'(ncnt);
            for (int i = 0; i < NIN; i++)  in_rdy[i]  <= (SIZE - ncnt) > i;
            for (int j = 0; j < NOUT; j++) out_val[j] <= ncnt > j;
        end
    end

    // NOTE: the storage array has no reset; contents are only observable behind a valid flag.
    always_ff @(posedge clk) begin
        if (!init) begin
            for (int i = 0; i < NIN; i++) begin
                if (i < npush) mem[wrap(int'(wptr) + i)] <= in[i];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NOUT; j++) out[j] = mem[wrap(int'(rptr) + j)];
    end

    assign almost_full = int'(count) >= (SIZE - AF_MARGIN);

`ifdef QUEUE_MP_HWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  hwm <= '0;
        else if (init)               hwm <= '0;
        else if (ncnt > int'(hwm))   hwm <= CNTW'(ncnt);
    end
`else
    // High-water tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_queue_mp.sv
// Directed self-checking bench for queue_mp: an 8-entry 2-in/2-out instance and a 5-entry 1-in/2-out instance.
module tb_queue_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: SIZE=8, NIN=2, NOUT=2, AF_MARGIN=2
    logic        init;
    logic [3:0]  count;
    logic        almost_full;
    logic [1:0]  in_val, in_rdy, out_val, out_rdy;
    logic [31:0] din [2];
    logic [31:0] dout [2];
`ifdef QUEUE_MP_HWM_EN
    logic [3:0]  hwm;
`endif

    queue_mp #(.SIZE(8), .NIN(2), .NOUT(2), .AF_MARGIN(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .init(init), .count(count), .almost_full(almost_full),
        .in_val(in_val), .in_rdy(in_rdy), .in(din),
        .out_val(out_val), .out_rdy(out_rdy), .out(dout)
`ifdef QUEUE_MP_HWM_EN
        , .hwm(hwm)
`endif
    );

    // Small instance: SIZE=5, NIN=1, NOUT=2, AF_MARGIN=1
    logic        s_init;
    logic [2:0]  s_count;
    logic        s_almost_full;
    logic [0:0]  s_in_val, s_in_rdy;
    logic [1:0]  s_out_val, s_out_rdy;
    logic [31:0] s_din [1];
    logic [31:0] s_dout [2];
`ifdef QUEUE_MP_HWM_EN
    logic [2:0]  s_hwm;
`endif

    queue_mp #(.SIZE(5), .NIN(1), .NOUT(2), .AF_MARGIN(1)) u_small (
        .clk(clk), .rst_n(rst_n), .init(s_init), .count(s_count), .almost_full(s_almost_full),
        .in_val(s_in_val), .in_rdy(s_in_rdy), .in(s_din),
        .out_val(s_out_val), .out_rdy(s_out_rdy), .out(s_dout)
`ifdef QUEUE_MP_HWM_EN
        , .hwm(s_hwm)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0; init = 1'b0; in_val = '0; out_rdy = '0; din[0] = '0; din[1] = '0;
        s_init = 1'b0; s_in_val = '0; s_out_rdy = '0; s_din[0] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (count !== 4'd0)     begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (in_rdy !== 2'b11)   begin n_fail++; $display("FAIL reset_in_rdy got %b want 11", in_rdy); end
        n_checks++; if (out_val !== 2'b00)  begin n_fail++; $display("FAIL reset_out_val got %b want 00", out_val); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", almost_full); end
        n_checks++; if (s_count !== 3'd0 || s_in_rdy !== 1'b1 || s_out_val !== 2'b00)
            begin n_fail++; $display("FAIL reset_small got cnt=%0d rdy=%b val=%b want 0/1/00", s_count, s_in_rdy, s_out_val); end
`ifdef QUEUE_MP_HWM_EN
        n_checks++; if (hwm !== 4'd0) begin n_fail++; $display("FAIL reset_hwm got %0d want 0", hwm); end
`endif
    endtask

    task automatic test_lane_gap();
        // lane 0 low, lane 1 high: nothing may be written
        in_val = 2'b10; din[0] = 32'd90; din[1] = 32'd91;
        @(negedge clk);
        in_val = 2'b00;
        n_checks++; if (count !== 4'd0)    begin n_fail++; $display("FAIL gap_count got %0d want 0", count); end
        n_checks++; if (out_val !== 2'b00) begin n_fail++; $display("FAIL gap_out_val got %b want 00", out_val); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            in_val = 2'b11; din[0] = 32'(2*k + 1); din[1] = 32'(2*k + 2);
            @(negedge clk);
        end
        in_val = 2'b00;
        n_checks++; if (count !== 4'd8)       begin n_fail++; $display("FAIL fill_count got %0d want 8", count); end
        n_checks++; if (in_rdy !== 2'b00)     begin n_fail++; $display("FAIL fill_in_rdy got %b want 00", in_rdy); end
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af got %b want 1", almost_full); end
        n_checks++; if (out_val !== 2'b11)    begin n_fail++; $display("FAIL fill_out_val got %b want 11", out_val); end
        n_checks++; if (dout[0] !== 32'd1)    begin n_fail++; $display("FAIL fill_out0 got %0d want 1", dout[0]); end
        n_checks++; if (dout[1] !== 32'd2)    begin n_fail++; $display("FAIL fill_out1 got %0d want 2", dout[1]); end
`ifdef QUEUE_MP_HWM_EN
        n_checks++; if (hwm !== 4'd8) begin n_fail++; $display("FAIL fill_hwm got %0d want 8", hwm); end
`endif
    endtask

    task automatic test_full_pop();
        // pop two while offering two; the push must be refused in the full cycle
        in_val = 2'b11; din[0] = 32'd99; din[1] = 32'd98; out_rdy = 2'b11;
        @(negedge clk);
        in_val = 2'b00; out_rdy = 2'b00;
        n_checks++; if (count !== 4'd6)       begin n_fail++; $display("FAIL fullpop_count got %0d want 6", count); end
        n_checks++; if (in_rdy !== 2'b11)     begin n_fail++; $display("FAIL fullpop_in_rdy got %b want 11", in_rdy); end
        n_checks++; if (dout[0] !== 32'd3)    begin n_fail++; $display("FAIL fullpop_out0 got %0d want 3", dout[0]); end
        n_checks++; if (dout[1] !== 32'd4)    begin n_fail++; $display("FAIL fullpop_out1 got %0d want 4", dout[1]); end
        n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fullpop_af got %b want 1", almost_full); end
        // single pop down to 5: almost_full drops
        out_rdy = 2'b01;
        @(negedge clk);
        out_rdy = 2'b00;
        n_checks++; if (count !== 4'd5)       begin n_fail++; $display("FAIL pop1_count got %0d want 5", count); end
        n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL pop1_af got %b want 0", almost_full); end
        n_checks++; if (dout[0] !== 32'd4)    begin n_fail++; $display("FAIL pop1_out0 got %0d want 4", dout[0]); end
    endtask

    task automatic test_init();
        in_val = 2'b11; din[0] = 32'd77; din[1] = 32'd78; out_rdy = 2'b11; init = 1'b1;
        @(negedge clk);
        in_val = 2'b00; out_rdy = 2'b00; init = 1'b0;
        n_checks++; if (count !== 4'd0)    begin n_fail++; $display("FAIL init_count got %0d want 0", count); end
        n_checks++; if (out_val !== 2'b00) begin n_fail++; $display("FAIL init_out_val got %b want 00", out_val); end
        n_checks++; if (in_rdy !== 2'b11)  begin n_fail++; $display("FAIL init_in_rdy got %b want 11", in_rdy); end
`ifdef QUEUE_MP_HWM_EN
        n_checks++; if (hwm !== 4'd0) begin n_fail++; $display("FAIL init_hwm got %0d want 0", hwm); end
`endif
        // the first push after init must be the head, not the dropped 77/78
        in_val = 2'b01; din[0] = 32'd50;
        @(negedge clk);
        in_val = 2'b00;
        n_checks++; if (count !== 4'd1 || out_val !== 2'b01)
            begin n_fail++; $display("FAIL postinit_state got cnt=%0d val=%b want 1/01", count, out_val); end
        n_checks++; if (dout[0] !== 32'd50) begin n_fail++; $display("FAIL postinit_out0 got %0d want 50", dout[0]); end
    endtask

    task automatic test_back_to_back();
        // count 1 -> push 2, pop 1 in the same cycle -> count 2, head 60
        in_val = 2'b11; din[0] = 32'd60; din[1] = 32'd61; out_rdy = 2'b11;
        @(negedge clk);
        in_val = 2'b00; out_rdy = 2'b00;
        n_checks++; if (count !== 4'd2)     begin n_fail++; $display("FAIL b2b_count got %0d want 2", count); end
        n_checks++; if (dout[0] !== 32'd60) begin n_fail++; $display("FAIL b2b_out0 got %0d want 60", dout[0]); end
        n_checks++; if (dout[1] !== 32'd61) begin n_fail++; $display("FAIL b2b_out1 got %0d want 61", dout[1]); end
    endtask

    task automatic test_wrap();
        logic [1:0] pat [12];
        int nxt_in, nxt_out, cyc, np;
        logic stop;
        pat = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
        nxt_in = 0; nxt_out = 0; cyc = 0;
        while (nxt_out < 20 && cyc < 300) begin
            @(negedge clk);
            n_checks++; if (s_count > 3'd5) begin n_fail++; $display("FAIL wrap_count got %0d want <=5", s_count); end
            s_in_val  = (nxt_in < 20) ? 1'b1 : 1'b0;
            s_din[0]  = 32'(nxt_in);
            s_out_rdy = pat[cyc % 12];
            if (s_in_val[0] && s_in_rdy[0]) nxt_in++;
            np = 0; stop = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (!stop && s_out_val[j] && s_out_rdy[j]) begin
                    n_checks++;
                    if (s_dout[j] !== 32'(nxt_out + np)) begin
                        n_fail++; $display("FAIL wrap_order lane %0d got %0d want %0d", j, s_dout[j], nxt_out + np);
                    end
                    np++;
                end else stop = 1'b1;
            end
            nxt_out += np;
            cyc++;
        end
        @(negedge clk);
        s_in_val = '0; s_out_rdy = '0;
        n_checks++; if (nxt_out != 20) begin n_fail++; $display("FAIL wrap_done got %0d want 20", nxt_out); end
    endtask

    initial begin
        test_reset();
        test_lane_gap();
        test_fill();
        test_full_pop();
        test_init();
        test_back_to_back();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
